cpu_run_controller: RTL and testbench

Synthesisable run controller for the ARM_CPU core. It replaces the fixed reset pulse and fixed simulation length of the top-level harness with a parametrised sequence: hold the core in reset, release it, and monitor the data-memory bus for a "tohost" completion store. It also detects PC hangs and cycle timeouts, counts loads and stores, and reports a latched verdict. It sits beside the core, IC and Data_Memory, tapping the core's PC and memory-control wires and driving the core's reset input.

---
 rtl/cpu_run_controller.sv | 154 +++++++++++++++
 tb/tb_cpu_run_controller.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_controller.sv
// rtl/cpu_run_controller.sv - run controller: reset sequencing, tohost completion, hang/timeout detection, run statistics
//
// Ports:
//   CLOCK, RESET        clock (rising edge) and asynchronous active-low reset
//   start               begin or restart a run (accepted in IDLE and DONE)
//   pc                  core program counter, used for hang detection
//   mem_address         core data-memory address
//   mem_data_in         core store data
//   control_memwrite    core store strobe
//   control_memread     core load strobe
//   core_reset          active-high reset driven to the core
//   running             high while the core is executing
//   done                verdict valid (latched until restart)
//   status              0 none, 1 pass, 2 fail, 3 timeout, 4 hang
//   fail_value          data of a failing tohost store
//   cycle_count, store_count, load_count   saturating run statistics
module cpu_run_controller #(
  parameter int                    ADDR_WIDTH  = 64,
  parameter int                    DATA_WIDTH  = 64,
  parameter int                    CNT_WIDTH   = 32,
  parameter int                    HOLD_CYCLES = 4,
  parameter int                    MAX_CYCLES  = 15,
  parameter int                    STALL_LIMIT = 8,
  parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR = 64'h0000_0000_0000_00F8,
  parameter logic [DATA_WIDTH-1:0] PASS_VALUE  = 64'h1
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic [ADDR_WIDTH-1:0] mem_address,
  input  logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic                  control_memwrite,
  input  logic                  control_memread,
  output logic                  core_reset,
  output logic                  running,
  output logic                  done,
  output logic [2:0]            status,
  output logic [DATA_WIDTH-1:0] fail_value,
  output logic [CNT_WIDTH-1:0]  cycle_count,
  output logic [CNT_WIDTH-1:0]  store_count,
  output logic [CNT_WIDTH-1:0]  load_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_RUN, ST_DONE} state_t;

  localparam logic [CNT_WIDTH-1:0] LP_ONE       = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] LP_HOLD_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] LP_MAX       = CNT_WIDTH'(MAX_CYCLES);
  localparam logic [CNT_WIDTH-1:0] LP_STALL     = CNT_WIDTH'(STALL_LIMIT);

  state_t                r_state, w_next;
  logic [1:0]            r_rst_sync;
  logic [CNT_WIDTH-1:0]  r_hold_cnt;
  logic [CNT_WIDTH-1:0]  r_stall_cnt;
  logic [ADDR_WIDTH-1:0] r_pc_prev;
  logic                  r_first;
  logic [CNT_WIDTH-1:0]  w_stall_next, w_cycle_next, w_store_next, w_load_next;
  logic                  w_tohost, w_hang, w_timeout, w_enter_hold;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + LP_ONE;
  endfunction

  // Reset release is only honoured once it has passed through two flops,
  // so the FSM cannot react to a start on the edge where RESET rises.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    // The first RUN cycle only primes pc_prev, so the stall count starts at zero there.
    w_stall_next = '0;
    if (!r_first && (pc == r_pc_prev)) w_stall_next = sat_inc(r_stall_cnt);
    w_cycle_next = sat_inc(cycle_count);
    w_store_next = control_memwrite ? sat_inc(store_count) : store_count;
    w_load_next  = control_memread  ? sat_inc(load_count)  : load_count;
    w_tohost     = control_memwrite && (mem_address == TOHOST_ADDR);
    w_hang       = (STALL_LIMIT != 0) && (w_stall_next == LP_STALL);
    w_timeout    = (w_cycle_next == LP_MAX);

    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start && r_rst_sync[1])           w_next = ST_HOLD;
      ST_HOLD: if (r_hold_cnt == LP_HOLD_LAST)       w_next = ST_RUN;
      ST_RUN:  if (w_tohost || w_hang || w_timeout)  w_next = ST_DONE;
      ST_DONE: if (start)                            w_next = ST_HOLD;
      default:                                       w_next = ST_IDLE;
    endcase
    w_enter_hold = (w_next == ST_HOLD) && (r_state != ST_HOLD);
  end

  // Outputs are registered from the next state so they change on the same
  // edge as the state itself.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      core_reset  <= 1'b1;
      running     <= 1'b0;
      done        <= 1'b0;
      status      <= 3'd0;
      fail_value  <= '0;
      cycle_count <= '0;
      store_count <= '0;
      load_count  <= '0;
      r_hold_cnt  <= '0;
      r_stall_cnt <= '0;
      r_pc_prev   <= '0;
      r_first     <= 1'b1;
    end else begin
      core_reset <= (w_next != ST_RUN);
      running    <= (w_next == ST_RUN);
      done       <= (w_next == ST_DONE);
      if (w_enter_hold) begin
        status      <= 3'd0;
        fail_value  <= '0;
        cycle_count <= '0;
        store_count <= '0;
        load_count  <= '0;
        r_hold_cnt  <= '0;
        r_stall_cnt <= '0;
        r_first     <= 1'b1;
      end else if (r_state == ST_HOLD) begin
        r_hold_cnt <= r_hold_cnt + LP_ONE;
      end else if (r_state == ST_RUN) begin
        cycle_count <= w_cycle_next;
        store_count <= w_store_next;
        load_count  <= w_load_next;
        r_stall_cnt <= w_stall_next;
        r_pc_prev   <= pc;
        r_first     <= 1'b0;
        // Priority: tohost store, then hang, then timeout.
        if (w_tohost) begin
          if (mem_data_in == PASS_VALUE) begin
            status <= 3'd1;
          end else begin
            status     <= 3'd2;
            fail_value <= mem_data_in;
          end
        end else if (w_hang) begin
          status <= 3'd4;
        end else if (w_timeout) begin
          status <= 3'd3;
        end
      end
    end
  end

endmodule

// File: tb/tb_cpu_run_controller.sv
// tb/tb_cpu_run_controller.sv - directed self-checking bench for cpu_run_controller
module tb_cpu_run_controller;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        start, start_h;
  logic [63:0] pc, mem_address, mem_data_in;
  logic        control_memwrite, control_memread;

  logic        core_reset, running, done;
  logic [2:0]  status;
  logic [63:0] fail_value;
  logic [31:0] cycle_count, store_count, load_count;

  logic        h_core_reset, h_running, h_done;
  logic [2:0]  h_status;
  logic [63:0] h_fail_value;
  logic [31:0] h_cycle_count, h_store_count, h_load_count;

  logic        n_core_reset, n_running, n_done;
  logic [2:0]  n_status;
  logic [63:0] n_fail_value;
  logic [31:0] n_cycle_count, n_store_count, n_load_count;

  int total = 0;
  int bad   = 0;

  always #5 CLOCK = ~CLOCK;

  cpu_run_controller u_dut (
    .CLOCK(CLOCK), .RESET(RESET), .start(start), .pc(pc),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .control_memwrite(control_memwrite), .control_memread(control_memread),
    .core_reset(core_reset), .running(running), .done(done), .status(status),
    .fail_value(fail_value), .cycle_count(cycle_count),
    .store_count(store_count), .load_count(load_count));

  cpu_run_controller #(.MAX_CYCLES(100), .STALL_LIMIT(8)) u_dut_h (
    .CLOCK(CLOCK), .RESET(RESET), .start(start_h), .pc(pc),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .control_memwrite(control_memwrite), .control_memread(control_memread),
    .core_reset(h_core_reset), .running(h_running), .done(h_done), .status(h_status),
    .fail_value(h_fail_value), .cycle_count(h_cycle_count),
    .store_count(h_store_count), .load_count(h_load_count));

  cpu_run_controller #(.MAX_CYCLES(100), .STALL_LIMIT(0)) u_dut_n (
    .CLOCK(CLOCK), .RESET(RESET), .start(start_h), .pc(pc),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .control_memwrite(control_memwrite), .control_memread(control_memread),
    .core_reset(n_core_reset), .running(n_running), .done(n_done), .status(n_status),
    .fail_value(n_fail_value), .cycle_count(n_cycle_count),
    .store_count(n_store_count), .load_count(n_load_count));

  // One clock: inputs set at a falling edge are sampled at the next rising
  // edge, outputs are observed at the falling edge after it.
  task automatic step();
    @(posedge CLOCK);
    @(negedge CLOCK);
  endtask

  task automatic do_start(input bit hang_pair);
    if (hang_pair) start_h = 1'b1; else start = 1'b1;
    step();
    start   = 1'b0;
    start_h = 1'b0;
  endtask

  // Drive one RUN cycle of core activity, then return strobes to idle.
  task automatic run_cyc(input logic [63:0] p, input logic wr, input logic rd,
                         input logic [63:0] a, input logic [63:0] d);
    pc = p; control_memwrite = wr; control_memread = rd;
    mem_address = a; mem_data_in = d;
    step();
    control_memwrite = 1'b0; control_memread = 1'b0;
    mem_address = 64'h0; mem_data_in = 64'h0;
  endtask

  task automatic test_reset();
    RESET = 1'b0; start = 1'b0; start_h = 1'b0; pc = 64'h0;
    mem_address = 64'h0; mem_data_in = 64'h0;
    control_memwrite = 1'b0; control_memread = 1'b0;
    @(negedge CLOCK);
    total++; if (core_reset !== 1'b1) begin bad++; $display("FAIL rst_core_reset got=%b exp=1", core_reset); end
    total++; if (running !== 1'b0) begin bad++; $display("FAIL rst_running got=%b exp=0", running); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
    total++; if (status !== 3'd0) begin bad++; $display("FAIL rst_status got=%0d exp=0", status); end
    total++; if (fail_value !== 64'h0) begin bad++; $display("FAIL rst_fail_value got=%h exp=0", fail_value); end
    total++; if ({cycle_count, store_count, load_count} !== 96'h0) begin bad++;
      $display("FAIL rst_counts got=%0d/%0d/%0d exp=0/0/0", cycle_count, store_count, load_count); end
    // A start on the very first edge after RESET rises must be ignored.
    RESET = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (6) step();
    total++; if (running !== 1'b0 || core_reset !== 1'b1) begin bad++;
      $display("FAIL early_start_ignored got running=%b core_reset=%b exp running=0 core_reset=1", running, core_reset); end
  endtask

  task automatic test_timeout();
    do_start(1'b0);
    for (int k = 0; k < 4; k++) begin
      total++; if (core_reset !== 1'b1 || running !== 1'b0) begin bad++;
        $display("FAIL hold_%0d got core_reset=%b running=%b exp core_reset=1 running=0", k, core_reset, running); end
      step();
    end
    total++; if (core_reset !== 1'b0 || running !== 1'b1) begin bad++;
      $display("FAIL run_entry got core_reset=%b running=%b exp core_reset=0 running=1", core_reset, running); end
    for (int i = 1; i <= 15; i++) begin
      run_cyc(64'h1000 + 64'(4 * i), 1'b0, (i == 2 || i == 3), 64'h0, 64'h0);
      if (i == 14) begin
        total++; if (done !== 1'b0) begin bad++; $display("FAIL timeout_early got done=%b exp=0", done); end
      end
    end
    total++; if (done !== 1'b1 || status !== 3'd3) begin bad++;
      $display("FAIL timeout_verdict got done=%b status=%0d exp done=1 status=3", done, status); end
    total++; if (cycle_count !== 32'd15) begin bad++; $display("FAIL timeout_cycles got=%0d exp=15", cycle_count); end
    total++; if (load_count !== 32'd2 || store_count !== 32'd0) begin bad++;
      $display("FAIL timeout_ldst got=%0d/%0d exp=2/0", load_count, store_count); end
    total++; if (core_reset !== 1'b1 || running !== 1'b0) begin bad++;
      $display("FAIL timeout_core_reset got core_reset=%b running=%b exp 1/0", core_reset, running); end
    repeat (2) step();
    total++; if (cycle_count !== 32'd15 || status !== 3'd3) begin bad++;
      $display("FAIL done_hold got cycles=%0d status=%0d exp 15/3", cycle_count, status); end
  endtask

  task automatic test_pass();
    do_start(1'b0);
    total++; if (status !== 3'd0 || done !== 1'b0 || cycle_count !== 32'd0) begin bad++;
      $display("FAIL restart_clear got status=%0d done=%b cycles=%0d exp 0/0/0", status, done, cycle_count); end
    repeat (4) step();
    for (int i = 1; i <= 5; i++) run_cyc(64'h1000 + 64'(4 * i), 1'b0, (i == 1), 64'h0, 64'h0);
    total++; if (core_reset !== 1'b0 || done !== 1'b0) begin bad++;
      $display("FAIL pass_pre got core_reset=%b done=%b exp 0/0", core_reset, done); end
    run_cyc(64'h1018, 1'b1, 1'b0, 64'hF8, 64'h1);
    total++; if (done !== 1'b1 || status !== 3'd1) begin bad++;
      $display("FAIL pass_verdict got done=%b status=%0d exp 1/1", done, status); end
    total++; if (cycle_count !== 32'd6 || store_count !== 32'd1 || load_count !== 32'd1) begin bad++;
      $display("FAIL pass_counts got=%0d/%0d/%0d exp=6/1/1", cycle_count, store_count, load_count); end
    total++; if (core_reset !== 1'b1) begin bad++; $display("FAIL pass_core_reset got=%b exp=1", core_reset); end
  endtask

  task automatic test_fail();
    do_start(1'b0);
    repeat (4) step();
    run_cyc(64'h1004, 1'b1, 1'b0, 64'h100, 64'h55);
    run_cyc(64'h1008, 1'b0, 1'b0, 64'h0, 64'h0);
    run_cyc(64'h100C, 1'b1, 1'b0, 64'hF8, 64'hDEAD);
    total++; if (done !== 1'b1 || status !== 3'd2) begin bad++;
      $display("FAIL fail_verdict got done=%b status=%0d exp 1/2", done, status); end
    total++; if (fail_value !== 64'hDEAD) begin bad++; $display("FAIL fail_value got=%h exp=dead", fail_value); end
    total++; if (cycle_count !== 32'd3 || store_count !== 32'd2) begin bad++;
      $display("FAIL fail_counts got=%0d/%0d exp=3/2", cycle_count, store_count); end
  endtask

  // pc frozen from RUN cycle 7: the stall count reaches 8 on cycle 15, the
  // same cycle as the timeout.
  task automatic test_coincide(input bit with_store);
    do_start(1'b0);
    repeat (4) step();
    for (int i = 1; i <= 15; i++) begin
      run_cyc((i < 7) ? 64'h1000 + 64'(4 * i) : 64'h40,
              with_store && (i == 15), 1'b0, 64'hF8, 64'h1);
      if (i == 14) begin
        total++; if (done !== 1'b0) begin bad++; $display("FAIL coincide_early got done=%b exp=0", done); end
      end
    end
    total++; if (done !== 1'b1 || status !== (with_store ? 3'd1 : 3'd4) || cycle_count !== 32'd15) begin bad++;
      $display("FAIL coincide_store%0d got done=%b status=%0d cycles=%0d exp 1/%0d/15",
               with_store, done, status, cycle_count, with_store ? 1 : 4); end
  endtask

  task automatic test_hang();
    do_start(1'b1);
    repeat (4) step();
    for (int i = 1; i <= 100; i++) begin
      run_cyc((i < 3) ? 64'h2000 + 64'(4 * i) : 64'h40, 1'b0, 1'b0, 64'h0, 64'h0);
      if (i == 10) begin
        total++; if (h_done !== 1'b0) begin bad++; $display("FAIL hang_early got done=%b exp=0", h_done); end
      end
      if (i == 11) begin
        total++; if (h_done !== 1'b1 || h_status !== 3'd4 || h_cycle_count !== 32'd11) begin bad++;
          $display("FAIL hang_verdict got done=%b status=%0d cycles=%0d exp 1/4/11", h_done, h_status, h_cycle_count); end
      end
      if (i == 99) begin
        total++; if (n_done !== 1'b0) begin bad++; $display("FAIL nohang_early got done=%b exp=0", n_done); end
      end
    end
    total++; if (n_done !== 1'b1 || n_status !== 3'd3 || n_cycle_count !== 32'd100) begin bad++;
      $display("FAIL nohang_timeout got done=%b status=%0d cycles=%0d exp 1/3/100", n_done, n_status, n_cycle_count); end
  endtask

  task automatic test_reset_mid_run();
    do_start(1'b0);
    repeat (4) step();
    for (int i = 1; i <= 6; i++) run_cyc(64'h1000 + 64'(4 * i), (i == 2), (i == 4), 64'h200, 64'h7);
    #2 RESET = 1'b0;
    #1;
    total++; if (core_reset !== 1'b1 || running !== 1'b0 || done !== 1'b0) begin bad++;
      $display("FAIL midrst_ctrl got core_reset=%b running=%b done=%b exp 1/0/0", core_reset, running, done); end
    total++; if ({cycle_count, store_count, load_count} !== 96'h0) begin bad++;
      $display("FAIL midrst_counts got=%0d/%0d/%0d exp=0/0/0", cycle_count, store_count, load_count); end
    @(negedge CLOCK);
    RESET = 1'b1;
    repeat (3) step();
    total++; if (running !== 1'b0) begin bad++; $display("FAIL midrst_no_resume got running=%b exp=0", running); end
    do_start(1'b0);
    repeat (3) step();
    total++; if (core_reset !== 1'b1) begin bad++; $display("FAIL clean_hold got core_reset=%b exp=1", core_reset); end
    step();
    run_cyc(64'h3000, 1'b1, 1'b0, 64'h300, 64'h9);
    run_cyc(64'h3004, 1'b0, 1'b0, 64'h0, 64'h0);
    total++; if (running !== 1'b1 || cycle_count !== 32'd2 || store_count !== 32'd1) begin bad++;
      $display("FAIL clean_run got running=%b cycles=%0d stores=%0d exp 1/2/1", running, cycle_count, store_count); end
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_pass();
    test_fail();
    test_coincide(1'b0);
    test_coincide(1'b1);
    test_hang();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
